mul_arbiter: RTL

- Shares one pipelined 32x32 signed radix-4 Booth multiplier (`mul`, WIDTH=32) between two requesters, e.g. the NTT butterfly and the basemul unit.
- `mul` is fully pipelined: fixed 17-cycle latency, no stall input, no valid signal.
  - This block adds round-robin issue, a valid/tag shadow pipeline and per-port response FIFOs.
  - Credit-based flow control guarantees no result is ever dropped.

---
 rtl/mul_arb_pkg.sv | 16 +
 rtl/mul.sv | 34 +++
 rtl/rsp_fifo.sv | 48 ++++
 rtl/mul_arbiter.sv | 123 ++++++++++++
 4 files changed

// File: rtl/mul_arb_pkg.sv
// Shared constants and types for the two-port multiplier arbiter.
package mul_arb_pkg;

    localparam int WIDTH   = 32;
    localparam int TAG_W   = 8;
    localparam int MUL_LAT = 17;

    typedef logic port_id_t;

    typedef struct packed {
        logic             v;
        port_id_t         id;
        logic [TAG_W-1:0] tag;
    } shadow_t;

endpackage

// File: rtl/mul.sv
// Fully pipelined signed multiplier: the product is formed at the sampling edge
// and carried down a LAT-deep register chain, so R is valid LAT edges later.
module mul #(
    parameter int WIDTH = 32,
    parameter int LAT   = 17
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [WIDTH-1:0]   i_a,
    input  logic [WIDTH-1:0]   i_b,
    output logic [2*WIDTH-1:0] o_r
);

    logic signed [2*WIDTH-1:0] w_a;
    logic signed [2*WIDTH-1:0] w_b;
    logic signed [2*WIDTH-1:0] w_prod;
    logic [2*WIDTH-1:0]        r_pipe [LAT];

    assign w_a    = {{WIDTH{i_a[WIDTH-1]}}, i_a};
    assign w_b    = {{WIDTH{i_b[WIDTH-1]}}, i_b};
    assign w_prod = w_a * w_b;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < LAT; i++) r_pipe[i] <= '0;
        end else begin
            r_pipe[0] <= w_prod;
            for (int i = 1; i < LAT; i++) r_pipe[i] <= r_pipe[i-1];
        end
    end

    assign o_r = r_pipe[LAT-1];

endmodule

// File: rtl/rsp_fifo.sv
// First-word-fall-through response FIFO; the head word reads as zero when empty.
module rsp_fifo #(
    parameter int DEPTH = 32,
    parameter int DW    = 72
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          i_wr_en,
    input  logic [DW-1:0] i_wr_data,
    input  logic          i_rd_en,
    output logic          o_valid,
    output logic [DW-1:0] o_rd_data
);

    localparam int AW = $clog2(DEPTH);

    logic [DW-1:0] r_mem [DEPTH];
    logic [AW:0]   r_wrPtr;
    logic [AW:0]   r_rdPtr;
    logic          w_empty;
    logic          w_full;

    assign w_empty = (r_wrPtr == r_rdPtr);
    assign w_full  = (r_wrPtr[AW] != r_rdPtr[AW]) && (r_wrPtr[AW-1:0] == r_rdPtr[AW-1:0]);

    always_ff @(posedge clk) begin
        if (i_wr_en && !w_full) r_mem[r_wrPtr[AW-1:0]] <= i_wr_data;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wrPtr <= '0;
            r_rdPtr <= '0;
        end else begin
            if (i_wr_en && !w_full) r_wrPtr <= r_wrPtr + 1'b1;
            if (i_rd_en && !w_empty) r_rdPtr <= r_rdPtr + 1'b1;
        end
    end

    // Credit flow control upstream must make a write into a full FIFO impossible.
    always_ff @(posedge clk) begin
        if (rst_n) assert (!(i_wr_en && w_full));
    end

    assign o_valid   = !w_empty;
    assign o_rd_data = w_empty ? '0 : r_mem[r_rdPtr[AW-1:0]];

endmodule

// File: rtl/mul_arbiter.sv
// Round-robin sharing of one pipelined multiplier between two requesters, with a
// tag shadow pipe and credit-protected per-port response FIFOs.
module mul_arbiter
    import mul_arb_pkg::*;
#(
    parameter int RSP_DEPTH = 32
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               req0_valid,
    output logic               req0_ready,
    input  logic [WIDTH-1:0]   req0_a,
    input  logic [WIDTH-1:0]   req0_b,
    input  logic [TAG_W-1:0]   req0_tag,
    input  logic               req1_valid,
    output logic               req1_ready,
    input  logic [WIDTH-1:0]   req1_a,
    input  logic [WIDTH-1:0]   req1_b,
    input  logic [TAG_W-1:0]   req1_tag,
    output logic               rsp0_valid,
    input  logic               rsp0_ready,
    output logic [2*WIDTH-1:0] rsp0_r,
    output logic [TAG_W-1:0]   rsp0_tag,
    output logic               rsp1_valid,
    input  logic               rsp1_ready,
    output logic [2*WIDTH-1:0] rsp1_r,
    output logic [TAG_W-1:0]   rsp1_tag,
    output logic               busy
);

    localparam int CW = $clog2(RSP_DEPTH + 1);
    localparam int DW = 2*WIDTH + TAG_W;

    logic [CW-1:0]      r_credit0;
    logic [CW-1:0]      r_credit1;
    logic               r_lastGrant;
    shadow_t            r_shadow [MUL_LAT];
    shadow_t            w_issue;
    shadow_t            w_last;
    logic               w_elig0, w_elig1, w_grant0, w_grant1, w_pop0, w_pop1;
    logic [WIDTH-1:0]   w_mulA, w_mulB;
    logic [2*WIDTH-1:0] w_mulR;
    logic [DW-1:0]      w_rsp0Data, w_rsp1Data;

    // r_lastGrant=1 means port 1 won last, so port 0 has priority out of reset.
    assign w_elig0  = req0_valid && (r_credit0 < CW'(RSP_DEPTH));
    assign w_elig1  = req1_valid && (r_credit1 < CW'(RSP_DEPTH));
    assign w_grant0 = w_elig0 && (!w_elig1 || r_lastGrant);
    assign w_grant1 = w_elig1 && (!w_elig0 || !r_lastGrant);

    assign req0_ready = w_grant0;
    assign req1_ready = w_grant1;
    assign w_mulA = w_grant0 ? req0_a : (w_grant1 ? req1_a : '0);
    assign w_mulB = w_grant0 ? req0_b : (w_grant1 ? req1_b : '0);
    assign w_pop0 = rsp0_valid && rsp0_ready;
    assign w_pop1 = rsp1_valid && rsp1_ready;

    always_comb begin
        w_issue     = '0;
        w_issue.v   = w_grant0 || w_grant1;
        w_issue.id  = w_grant1;
        w_issue.tag = w_grant1 ? req1_tag : (w_grant0 ? req0_tag : '0);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_credit0   <= '0;
            r_credit1   <= '0;
            r_lastGrant <= 1'b1;
        end else begin
            if (w_grant0 && !w_pop0) r_credit0 <= r_credit0 + CW'(1);
            else if (!w_grant0 && w_pop0) r_credit0 <= r_credit0 - CW'(1);
            if (w_grant1 && !w_pop1) r_credit1 <= r_credit1 + CW'(1);
            else if (!w_grant1 && w_pop1) r_credit1 <= r_credit1 - CW'(1);
            if (w_grant0 || w_grant1) r_lastGrant <= w_grant1;
        end
    end

    // Shadow stage MUL_LAT-1 lines up with the multiplier output R.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < MUL_LAT; i++) r_shadow[i] <= '0;
        end else begin
            r_shadow[0] <= w_issue;
            for (int i = 1; i < MUL_LAT; i++) r_shadow[i] <= r_shadow[i-1];
        end
    end

    assign w_last = r_shadow[MUL_LAT-1];

    mul #(.WIDTH(WIDTH), .LAT(MUL_LAT)) u_mul (
        .clk   (clk),
        .rst_n (rst_n),
        .i_a   (w_mulA),
        .i_b   (w_mulB),
        .o_r   (w_mulR)
    );

    rsp_fifo #(.DEPTH(RSP_DEPTH), .DW(DW)) u_rsp0 (
        .clk       (clk),
        .rst_n     (rst_n),
        .i_wr_en   (w_last.v && (w_last.id == 1'b0)),
        .i_wr_data ({w_mulR, w_last.tag}),
        .i_rd_en   (w_pop0),
        .o_valid   (rsp0_valid),
        .o_rd_data (w_rsp0Data)
    );

    rsp_fifo #(.DEPTH(RSP_DEPTH), .DW(DW)) u_rsp1 (
        .clk       (clk),
        .rst_n     (rst_n),
        .i_wr_en   (w_last.v && (w_last.id == 1'b1)),
        .i_wr_data ({w_mulR, w_last.tag}),
        .i_rd_en   (w_pop1),
        .o_valid   (rsp1_valid),
        .o_rd_data (w_rsp1Data)
    );

    assign {rsp0_r, rsp0_tag} = w_rsp0Data;
    assign {rsp1_r, rsp1_tag} = w_rsp1Data;
    assign busy = (r_credit0 != '0) || (r_credit1 != '0);

endmodule
